// File: rtl/alu_if.sv
// alu_if: operand/opcode bundle into the ALU and registered result/flags
// back out. The master drives operands and opcode. The slave (the ALU)
// returns C and Flags.
interface alu_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [7:0]       Opcode;
  logic [WIDTH-1:0] C;
  logic [4:0]       Flags;

  modport master (output A, output B, output Opcode, input C, input Flags);
  modport slave  (input A, input B, input Opcode, output C, output Flags);
endinterface

// File: rtl/alu.sv
// alu: 16-bit integer ALU with registered result and Z/C/F/N/L flags.
// Operands and opcode are decoded to an internal operation plus an
// effective B operand. The result and flags load on every rising edge.
// Optional right shifts (RSH, RSHI, ARSH) are compiled in when the
// ALU_RSH_EN macro is defined. Otherwise those sub-ops act as NOPs.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_if.slave   bus
);

  localparam logic [3:0] CLS_BASE  = 4'b0000;
  localparam logic [3:0] CLS_ADDI  = 4'b0101;
  localparam logic [3:0] CLS_ADDUI = 4'b0110;
  localparam logic [3:0] CLS_ADDCI = 4'b0111;
  localparam logic [3:0] CLS_SHIFT = 4'b1000;
  localparam logic [3:0] CLS_SUBI  = 4'b1001;
  localparam logic [3:0] CLS_CMPI  = 4'b1011;

  typedef enum logic [4:0] {
    OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOT,
    OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU, OP_SUB,
    OP_CMP, OP_CMPU, OP_LSHI, OP_LSH,
    OP_RSH, OP_RSHI, OP_ARSH
  } op_e;

  // Bit order matches Flags[4:0] = {Z, C, F, N, L}.
  typedef struct packed {
    logic z;
    logic c;
    logic f;
    logic n;
    logic l;
  } flags_t;

  op_e              w_op;
  logic [WIDTH-1:0] w_b;
  logic [7:0]       w_imm8;
  logic [WIDTH-1:0] w_simm;
  logic [WIDTH-1:0] w_uimm;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_c_next;
  flags_t           w_flags_next;
  logic             w_z_en;
  logic [WIDTH-1:0] r_c;
  flags_t           r_flags;

  assign w_imm8 = {bus.Opcode[3:0], bus.B[3:0]};
  assign w_simm = {{(WIDTH-8){w_imm8[7]}}, w_imm8};
  assign w_uimm = {{(WIDTH-8){1'b0}}, w_imm8};

  // Decode the opcode into one operation and select the effective B operand.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_op = OP_NOP;
    w_b  = bus.B;
    case (bus.Opcode[7:4])
      CLS_BASE: begin
        case (bus.Opcode[3:0])
          4'b0001: w_op = OP_AND;
          4'b0010: w_op = OP_OR;
          4'b0011: w_op = OP_XOR;
          4'b0100: w_op = OP_NOT;
          4'b0101: w_op = OP_ADD;
          4'b0110: w_op = OP_ADDU;
          4'b0111: w_op = OP_ADDC;
          4'b1000: w_op = OP_ADDCU;
          4'b1001: w_op = OP_SUB;
          4'b1011: w_op = OP_CMP;
          4'b1111: w_op = OP_CMPU;
          default: w_op = OP_NOP;
        endcase
      end
      CLS_ADDI:  begin w_op = OP_ADD;  w_b = w_simm; end
      CLS_ADDUI: begin w_op = OP_ADDU; w_b = w_uimm; end
      CLS_ADDCI: begin w_op = OP_ADDC; w_b = w_simm; end
      CLS_SUBI:  begin w_op = OP_SUB;  w_b = w_simm; end
      CLS_CMPI:  begin w_op = OP_CMP;  w_b = w_simm; end
      CLS_SHIFT: begin
        case (bus.Opcode[3:0])
          4'b0000, 4'b0001: w_op = OP_LSHI;
          4'b0100:          w_op = OP_LSH;
`ifdef ALU_RSH_EN
          4'b1000:          w_op = OP_RSH;
          4'b1001:          w_op = OP_RSHI;
          4'b1100:          w_op = OP_ARSH;
`endif
          default:          w_op = OP_NOP;
        endcase
      end
      default: w_op = OP_NOP;
    endcase
  end

  // Shared adder: carry-in is set only for the ADDC family.
  assign w_cin  = (w_op == OP_ADDC) || (w_op == OP_ADDCU);
  assign w_sum  = {1'b0, bus.A} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff = bus.A - w_b;

  // Compute the next result and flags. Z follows the result for every
  // non-NOP, non-compare op.
  always_comb begin
    w_c_next     = '0;
    w_flags_next = '0;
    w_z_en       = 1'b1;
    case (w_op)
      OP_AND:  w_c_next = bus.A & w_b;
      OP_OR:   w_c_next = bus.A | w_b;
      OP_XOR:  w_c_next = bus.A ^ w_b;
      OP_NOT:  w_c_next = ~bus.A;
      OP_ADD, OP_ADDC: begin
        w_c_next       = w_sum[WIDTH-1:0];
        w_flags_next.f = (bus.A[WIDTH-1] == w_b[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
        w_flags_next.c = (w_op == OP_ADDC) ? w_sum[WIDTH] : 1'b0;
      end
      OP_ADDU, OP_ADDCU: begin
        w_c_next       = w_sum[WIDTH-1:0];
        w_flags_next.c = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_c_next       = w_diff;
        w_flags_next.f = (bus.A[WIDTH-1] != w_b[WIDTH-1]) &&
                         (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_CMP: begin
        w_z_en         = 1'b0;
        w_flags_next.z = (bus.A == w_b);
        w_flags_next.n = ($signed(bus.A) < $signed(w_b));
      end
      OP_CMPU: begin
        w_z_en         = 1'b0;
        w_flags_next.z = (bus.A == w_b);
        w_flags_next.l = (bus.A < w_b);
      end
      // A shift amount of WIDTH or more drains every bit out, giving zero.
      OP_LSHI: w_c_next = bus.A << w_b;
      OP_LSH:  w_c_next = bus.A << 1;
      OP_RSH:  w_c_next = bus.A >> 1;
      OP_RSHI: w_c_next = bus.A >> w_b;
      OP_ARSH: w_c_next = $signed(bus.A) >>> 1;
      default: w_z_en   = 1'b0;
    endcase
    if (w_z_en) w_flags_next.z = (w_c_next == '0);
  end

  // Result and flag registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_c     <= '0;
      r_flags <= '0;
    end else begin
      r_c     <= w_c_next;
      r_flags <= w_flags_next;
    end
  end

  assign bus.C     = r_c;
  assign bus.Flags = r_flags;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed table-driven checks of the alu. It also runs hand
// sequences for reset, mid-cycle input changes and asynchronous reset
// during operation.
module tb_alu;

  logic clk;
  logic rst_n;

  alu_if #(.WIDTH(16)) u_if ();

  alu #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    logic [15:0] c;
    logic [4:0]  f;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [15:0] a,
                              input logic [15:0] b, input logic [7:0] op,
                              input logic [15:0] c, input logic [4:0] f);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.op = op; v.c = c; v.f = f;
    return v;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] op);
    u_if.A      = a;
    u_if.B      = b;
    u_if.Opcode = op;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk("and_zero", 16'h00F0, 16'h0F00, 8'h01, 16'h0000, 5'b10000));
    vecs.push_back(mk("or",       16'h00F0, 16'h0F00, 8'h02, 16'h0FF0, 5'b00000));
    vecs.push_back(mk("xor_same", 16'h1234, 16'h1234, 8'h03, 16'h0000, 5'b10000));
    vecs.push_back(mk("not_zero", 16'h0000, 16'h5555, 8'h04, 16'hFFFF, 5'b00000));
    vecs.push_back(mk("add_ovf",  16'h7FFF, 16'h0001, 8'h05, 16'h8000, 5'b00100));
    vecs.push_back(mk("addu_cy",  16'hFFFF, 16'h0001, 8'h06, 16'h0000, 5'b11000));
    vecs.push_back(mk("addc_ovf", 16'h7FFF, 16'h0000, 8'h07, 16'h8000, 5'b00100));
    vecs.push_back(mk("addcu_cy", 16'hFFFF, 16'h0000, 8'h08, 16'h0000, 5'b11000));
    vecs.push_back(mk("sub_ovf",  16'h8000, 16'h0001, 8'h09, 16'h7FFF, 5'b00100));
    vecs.push_back(mk("subi_m1",  16'h0003, 16'h000F, 8'h9F, 16'h0004, 5'b00000));
    vecs.push_back(mk("addi_m2",  16'h0010, 16'h000E, 8'h5F, 16'h000E, 5'b00000));
    vecs.push_back(mk("addui_80", 16'h0001, 16'h0000, 8'h68, 16'h0081, 5'b00000));
    vecs.push_back(mk("addci_cy", 16'h0005, 16'h000F, 8'h7F, 16'h0005, 5'b01000));
    vecs.push_back(mk("cmpi_lt",  16'hFFFE, 16'h000F, 8'hBF, 16'h0000, 5'b00010));
    vecs.push_back(mk("cmp_lt",   16'hFFFF, 16'h0001, 8'h0B, 16'h0000, 5'b00010));
    vecs.push_back(mk("cmpu_gt",  16'hFFFF, 16'h0001, 8'h0F, 16'h0000, 5'b00000));
    vecs.push_back(mk("cmpu_lt",  16'h0001, 16'hFFFF, 8'h0F, 16'h0000, 5'b00001));
    vecs.push_back(mk("cmp_eq",   16'h0009, 16'h0009, 8'h0B, 16'h0000, 5'b10000));
    vecs.push_back(mk("lshi_4",   16'h0003, 16'h0004, 8'h80, 16'h0030, 5'b00000));
    vecs.push_back(mk("lshi_16",  16'h0003, 16'h0010, 8'h81, 16'h0000, 5'b10000));
    vecs.push_back(mk("lsh_out",  16'h8000, 16'h0000, 8'h84, 16'h0000, 5'b10000));
    vecs.push_back(mk("lsh_1",    16'h4001, 16'h0000, 8'h84, 16'h8002, 5'b00000));
    vecs.push_back(mk("nop_0a",   16'h0005, 16'h0007, 8'h0A, 16'h0000, 5'b00000));
    vecs.push_back(mk("nop_shf",  16'h0001, 16'h0001, 8'h82, 16'h0000, 5'b00000));
    vecs.push_back(mk("nop_clsf", 16'h0001, 16'h0001, 8'hF0, 16'h0000, 5'b00000));
`ifdef ALU_RSH_EN
    vecs.push_back(mk("rsh",      16'h8001, 16'h0000, 8'h88, 16'h4000, 5'b00000));
    vecs.push_back(mk("rshi_4",   16'hF000, 16'h0004, 8'h89, 16'h0F00, 5'b00000));
    vecs.push_back(mk("rshi_16",  16'hF000, 16'h0010, 8'h89, 16'h0000, 5'b10000));
    vecs.push_back(mk("arsh",     16'h8001, 16'h0000, 8'h8C, 16'hC000, 5'b00000));
`else
    vecs.push_back(mk("rsh_nop",  16'h8001, 16'h0000, 8'h88, 16'h0000, 5'b00000));
    vecs.push_back(mk("rshi_nop", 16'hF000, 16'h0004, 8'h89, 16'h0000, 5'b00000));
    vecs.push_back(mk("arsh_nop", 16'h8001, 16'h0000, 8'h8C, 16'h0000, 5'b00000));
`endif

    // Reset holds outputs at zero before any clock edge.
    rst_n = 1'b0;
    drive(16'd5, 16'd7, 8'h05);
    #2;
    check("rst_c", u_if.C, 16'h0000);
    check("rst_flags", {11'b0, u_if.Flags}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_c", u_if.C, 16'd12);
    check("post_rst_flags", {11'b0, u_if.Flags}, 16'h0000);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].op);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_c"}, u_if.C, vecs[i].c);
      check({vecs[i].name, "_flags"}, {11'b0, u_if.Flags}, {11'b0, vecs[i].f});
    end

    // Inputs changed between edges do not reach the outputs until the next edge.
    @(negedge clk);
    drive(16'd1, 16'd2, 8'h05);
    @(posedge clk);
    #1;
    check("hold_first", u_if.C, 16'd3);
    #1;
    drive(16'd100, 16'd2, 8'h05);
    #2;
    check("hold_mid", u_if.C, 16'd3);
    @(posedge clk);
    #1;
    check("hold_next", u_if.C, 16'd102);

    // Asynchronous reset during operation clears outputs without an edge.
    @(negedge clk);
    drive(16'hFFFF, 16'h0001, 8'h06);
    @(posedge clk);
    #1;
    drive(16'h7FFF, 16'h0001, 8'h05);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_c", u_if.C, 16'h0000);
    check("arst_flags", {11'b0, u_if.Flags}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_resume_c", u_if.C, 16'h8000);
    check("arst_resume_flags", {11'b0, u_if.Flags}, 16'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
